reg_wr_arb: RTL
===============

# reg_wr_arb

Write-port arbiter and controller for a small bank of 8-bit processor registers. Two requesters share the single write port: ALU writeback (port A) and memory load return (port B). Grants use round-robin priority with an optional lock for back-to-back bursts. The block also provides one registered read port with write forwarding and a saturating stall counter for performance debug.

## Interface
- NREG, 4, number of 8-bit registers in the bank (power of two)
- AW, 2, register address width, log2(NREG)
- DW, 8, data width

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has a write pending
- a_lock  in  1  A requests to keep ownership after this beat
- a_addr  in  AW  A target register
- a_data  in  DW  A write data
- a_ready  out  1  A beat accepted this cycle
- b_valid, b_lock, b_addr, b_data, b_ready  same as A, for requester B
- rd_addr  in  AW  read address
- rd_data  out  DW  registered read data, 1-cycle latency
- stall_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  8  saturating count of stalled-requester cycles
- owner  out  2  00 idle, 01 A locked, 10 B locked

## Operation
- Transfer: valid && ready in the same cycle. The bank register at addr takes data on that rising edge.
- At most one ready is high per cycle. Each ready is combinational from valid, state and prio. It never depends on its own requester's data or addr.
- FSM states:
  - IDLE: if exactly one requester is valid, grant it. If both are valid, grant the one selected by prio (reset value: A).
  - LOCK_A: only A may be granted; b_ready=0 even when A is idle.
  - LOCK_B: mirror of LOCK_A for B.
- Transitions:
  - IDLE → LOCK_x on a transfer by x with x_lock=1.
  - LOCK_x → IDLE on a transfer by x with x_lock=0.
  - A LOCK_x state with x_valid=0 holds the lock; there is no timeout.
- prio: after any transfer by x, prio points to the other requester. In LOCK_x, prio is updated only on the releasing beat.
- Read port:
  - rd_data ← bank[rd_addr] each cycle.
  - If a transfer in the same cycle targets rd_addr, rd_data takes the new write data (forwarding).
- stall_cnt:
  - Increments in every cycle where some requester is valid and not ready.
  - Saturates at 255.
  - stall_clr has priority over increment: the counter becomes 0 that cycle.
- Boundary behaviour:
  - Both requesters valid to the same address: only the granted one writes; the other stays pending.
  - Write and read of the same address in one cycle: the new value is forwarded.
  - Reset asserted mid-lock: returns to IDLE immediately; any beat in that cycle is not written.

## Timing
- Reset values:
  - All bank registers 0.
  - rd_data=0, stall_cnt=0, owner=00.
  - State IDLE, prio=A.
  - a_ready=b_ready=0 while rst is low.
- Grant latency is 0 cycles: ready is asserted in the same cycle as valid when the requester is eligible.
- Write-to-read latency:
  - Data written at edge N is visible on rd_data after edge N+1 for a non-forwarded read.
  - With forwarding, it is visible after edge N itself.
- Sustained throughput is one write per cycle. Under contention without lock, A and B alternate every cycle.

## Structure
- Shared package `proc_pkg` holds:
  - FSM state encodings (IDLE, LOCK_A, LOCK_B).
  - owner encodings.
  - Default DW/AW constants used across the processor.
- Sub-module `rr_arb2` holds the 2-way round-robin grant logic and the prio flop. Its ports are req[1:0], hold[1:0], gnt[1:0], plus clk and rst.
- The bank storage is a flop array with per-entry write enable generated in reg_wr_arb.

## Test plan
- Reset then read: release rst, rd_addr=0..3 → rd_data=0x00 on each, stall_cnt=0, owner=00.
- Solo write: A writes 0x5A to r2 with B idle → a_ready=1 in the same cycle; rd_addr=2 next cycle → rd_data=0x5A.
- Contention: A and B both valid for 4 cycles (A→r1, B→r3, no lock) → grants A,B,A,B; stall_cnt=4; prio ends at A.
- Lock burst: B valid with lock for 3 beats, last beat lock=0, A valid throughout → a_ready=0 for all 3 beats; owner=10 until release; A granted on the following cycle.
- Forwarding: A writes 0xC3 to r0 while rd_addr=0 in the same cycle → rd_data=0xC3 after that edge.
- Reset mid-lock and saturation: assert rst in LOCK_A during an A beat → r0–r3 unchanged by that beat, owner=00. Hold B stalled for 300 cycles → stall_cnt=255; stall_clr → 0.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants, FSM and owner encodings
package proc_pkg;

    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int NREG = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOCK_A = 2'b01,
        ST_LOCK_B = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_t;

endpackage

// File: rtl/reg_wr_arb_if.sv
// rtl/reg_wr_arb_if.sv - requester, read and debug signals of the register write arbiter
interface reg_wr_arb_if #(
    parameter int AW = proc_pkg::AW,
    parameter int DW = proc_pkg::DW
);
    logic          a_valid;
    logic          a_lock;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic          b_lock;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          stall_clr;
    logic [7:0]    stall_cnt;
    logic [1:0]    owner;

    modport slave (
        input  a_valid, a_lock, a_addr, a_data,
        input  b_valid, b_lock, b_addr, b_data,
        input  rd_addr, stall_clr,
        output a_ready, b_ready, rd_data, stall_cnt, owner
    );

    modport master (
        output a_valid, a_lock, a_addr, a_data,
        output b_valid, b_lock, b_addr, b_data,
        output rd_addr, stall_clr,
        input  a_ready, b_ready, rd_data, stall_cnt, owner
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with ownership hold and prio flop
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] hold,
    output logic [1:0] gnt
);
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            if (hold[0])            gnt[0] = req[0];
            else if (hold[1])       gnt[1] = req[1];
            else if (req == 2'b11)  gnt = prio ? 2'b10 : 2'b01;
            else                    gnt = req;
        end
    end

    // prio is ignored while a hold is active, so flipping on every beat of a
    // burst leaves the same value as flipping only on the releasing beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         prio <= 1'b0;
        else if (gnt[0])  prio <= 1'b1;
        else if (gnt[1])  prio <= 1'b0;
    end
endmodule

// File: rtl/reg_wr_arb.sv
// rtl/reg_wr_arb.sv - shared register-bank write port with lockable round-robin arbitration
module reg_wr_arb
    import proc_pkg::*;
#(
    parameter int NREG = proc_pkg::NREG,
    parameter int AW   = proc_pkg::AW,
    parameter int DW   = proc_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    reg_wr_arb_if.slave   bus
);
    state_t        state;
    owner_t        owner_q;
    logic [1:0]    req, hold, gnt;
    logic          wr_en, stall;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NREG-1:0] we;
    logic [DW-1:0] bank [NREG];
    logic [DW-1:0] rd_q;
    logic [7:0]    stall_q;

    assign req  = {bus.b_valid, bus.a_valid};
    assign hold = {state == ST_LOCK_B, state == ST_LOCK_A};

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .hold (hold),
        .gnt  (gnt)
    );

    assign bus.a_ready = gnt[0];
    assign bus.b_ready = gnt[1];

    assign wr_en   = |gnt;
    assign wr_addr = gnt[1] ? bus.b_addr : bus.a_addr;
    assign wr_data = gnt[1] ? bus.b_data : bus.a_data;
    assign stall   = (bus.a_valid & ~gnt[0]) | (bus.b_valid & ~gnt[1]);

    always_comb begin
        we = '0;
        if (wr_en) we[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (we[i]) bank[i] <= wr_data;
        end
    end

    // Same-cycle write to the read address is forwarded past the bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               rd_q <= '0;
        else if (wr_en && wr_addr == bus.rd_addr) rd_q <= wr_data;
        else                                    rd_q <= bank[bus.rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         stall_q <= '0;
        else if (bus.stall_clr)           stall_q <= '0;
        else if (stall && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner_q <= OWN_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt[0] && bus.a_lock) begin
                        state   <= ST_LOCK_A;
                        owner_q <= OWN_A;
                    end else if (gnt[1] && bus.b_lock) begin
                        state   <= ST_LOCK_B;
                        owner_q <= OWN_B;
                    end
                end
                ST_LOCK_A: begin
                    if (gnt[0] && !bus.a_lock) begin
                        state   <= ST_IDLE;
                        owner_q <= OWN_IDLE;
                    end
                end
                ST_LOCK_B: begin
                    if (gnt[1] && !bus.b_lock) begin
                        state   <= ST_IDLE;
                        owner_q <= OWN_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    owner_q <= OWN_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data   = rd_q;
    assign bus.stall_cnt = stall_q;
    assign bus.owner     = owner_q;
endmodule
